// File: rtl/rs_ooo_station.sv
// Out-of-order reservation station for the ALU path: holds dispatched ops, snoops the
// CDB for operand wakeup and issues the oldest ready entry through a registered port.
module rs_ooo_station #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned ROB_W = 4,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned OP_W  = 6,
  parameter int unsigned IMM_W = 32,
  parameter int unsigned N_CDB = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     clr,
  input  logic                     disp_valid,
  input  logic [OP_W-1:0]          disp_op,
  input  logic [31:0]              disp_pc,
  input  logic [IMM_W-1:0]         disp_imm,
  input  logic [ROB_W-1:0]         disp_rd_tag,
  input  logic                     disp_rs1_wait,
  input  logic [ROB_W-1:0]         disp_rs1_tag,
  input  logic [XLEN-1:0]          disp_rs1_val,
  input  logic                     disp_rs2_wait,
  input  logic [ROB_W-1:0]         disp_rs2_tag,
  input  logic [XLEN-1:0]          disp_rs2_val,
  input  logic [N_CDB-1:0]         cdb_valid,
  input  logic [N_CDB*ROB_W-1:0]   cdb_tag,
  input  logic [N_CDB*XLEN-1:0]    cdb_value,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [OP_W-1:0]          iss_op,
  output logic [31:0]              iss_pc,
  output logic [IMM_W-1:0]         iss_imm,
  output logic [ROB_W-1:0]         iss_rd_tag,
  output logic [XLEN-1:0]          iss_rs1_val,
  output logic [XLEN-1:0]          iss_rs2_val,
  output logic                     rs_full,
  output logic [IDX_W:0]           free_cnt
);

  localparam int unsigned CNT_W = IDX_W + 1;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [31:0]      pc;
    logic [IMM_W-1:0] imm;
    logic [ROB_W-1:0] rd_tag;
    logic             rs1_wait;
    logic [ROB_W-1:0] rs1_tag;
    logic [XLEN-1:0]  rs1_val;
    logic             rs2_wait;
    logic [ROB_W-1:0] rs2_tag;
    logic [XLEN-1:0]  rs2_val;
  } entry_t;

  entry_t           ent_q   [DEPTH];
  logic [DEPTH-1:0] busy_q;
  // older_q[i][j] = 1: entry j was dispatched before entry i
  logic [DEPTH-1:0] older_q [DEPTH];

  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] sel_vec;
  logic             sel_any;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] alloc_idx;
  logic             alloc_found;
  logic             disp_acc;
  logic             iss_open;
  logic             iss_load;
  logic [CNT_W-1:0] free_nxt;
  entry_t           new_ent;
  logic [XLEN:0]    new_rs1;
  logic [XLEN:0]    new_rs2;

  // Returns {wait, value} after snooping all channels; lowest matching channel wins.
  function automatic logic [XLEN:0] snoop(
    input logic                   w,
    input logic [ROB_W-1:0]       t,
    input logic [XLEN-1:0]        v,
    input logic [N_CDB-1:0]       cv,
    input logic [N_CDB*ROB_W-1:0] ct,
    input logic [N_CDB*XLEN-1:0]  cval
  );
    logic [XLEN:0] r;
    logic          hit;
    r   = {w, v};
    hit = 1'b0;
    if (w) begin
      for (int unsigned c = 0; c < N_CDB; c++) begin
        if (!hit && cv[c] && (ct[c*ROB_W +: ROB_W] == t)) begin
          r   = {1'b0, cval[c*XLEN +: XLEN]};
          hit = 1'b1;
        end
      end
    end
    return r;
  endfunction

  // Oldest-ready select and lowest-free allocation
  always_comb begin
    ready_vec   = '0;
    sel_vec     = '0;
    sel_idx     = '0;
    alloc_idx   = '0;
    alloc_found = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ready_vec[i] = busy_q[i] & ~ent_q[i].rs1_wait & ~ent_q[i].rs2_wait;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      sel_vec[i] = ready_vec[i] && ((older_q[i] & ready_vec) == '0);
    end
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (sel_vec[i-1]) sel_idx = IDX_W'(i - 1);
      if (!busy_q[i-1]) begin
        alloc_idx   = IDX_W'(i - 1);
        alloc_found = 1'b1;
      end
    end
    sel_any = |sel_vec;
  end

  // Handshake decisions and the incoming entry with dispatch-cycle bypass
  always_comb begin
    disp_acc = disp_valid && !rs_full && alloc_found;
    iss_open = !iss_valid || iss_ready;
    iss_load = iss_open && sel_any;
    free_nxt = free_cnt + CNT_W'(iss_load) - CNT_W'(disp_acc);
    new_rs1  = snoop(disp_rs1_wait, disp_rs1_tag, disp_rs1_val, cdb_valid, cdb_tag, cdb_value);
    new_rs2  = snoop(disp_rs2_wait, disp_rs2_tag, disp_rs2_val, cdb_valid, cdb_tag, cdb_value);
    new_ent          = '0;
    new_ent.op       = disp_op;
    new_ent.pc       = disp_pc;
    new_ent.imm      = disp_imm;
    new_ent.rd_tag   = disp_rd_tag;
    new_ent.rs1_wait = new_rs1[XLEN];
    new_ent.rs1_tag  = disp_rs1_tag;
    new_ent.rs1_val  = new_rs1[XLEN-1:0];
    new_ent.rs2_wait = new_rs2[XLEN];
    new_ent.rs2_tag  = disp_rs2_tag;
    new_ent.rs2_val  = new_rs2[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      busy_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) older_q[i] <= '0;
      iss_valid   <= 1'b0;
      iss_op      <= '0;
      iss_pc      <= '0;
      iss_imm     <= '0;
      iss_rd_tag  <= '0;
      iss_rs1_val <= '0;
      iss_rs2_val <= '0;
      rs_full     <= 1'b0;
      free_cnt    <= CNT_W'(DEPTH);
    end else if (rdy) begin
      // Wakeup of waiting operands in busy entries
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (busy_q[i]) begin
          {ent_q[i].rs1_wait, ent_q[i].rs1_val} <= snoop(ent_q[i].rs1_wait, ent_q[i].rs1_tag,
              ent_q[i].rs1_val, cdb_valid, cdb_tag, cdb_value);
          {ent_q[i].rs2_wait, ent_q[i].rs2_val} <= snoop(ent_q[i].rs2_wait, ent_q[i].rs2_tag,
              ent_q[i].rs2_val, cdb_valid, cdb_tag, cdb_value);
        end
      end
      if (iss_load) begin
        busy_q[sel_idx] <= 1'b0;
        iss_valid       <= 1'b1;
        iss_op          <= ent_q[sel_idx].op;
        iss_pc          <= ent_q[sel_idx].pc;
        iss_imm         <= ent_q[sel_idx].imm;
        iss_rd_tag      <= ent_q[sel_idx].rd_tag;
        iss_rs1_val     <= ent_q[sel_idx].rs1_val;
        iss_rs2_val     <= ent_q[sel_idx].rs2_val;
      end else if (iss_open) begin
        iss_valid <= 1'b0;
      end
      // New entry is younger than every busy entry; stale column bits are cleared
      if (disp_acc) begin
        busy_q[alloc_idx] <= 1'b1;
        ent_q[alloc_idx]  <= new_ent;
        for (int unsigned i = 0; i < DEPTH; i++) older_q[i][alloc_idx] <= 1'b0;
        older_q[alloc_idx] <= busy_q;
      end
      free_cnt <= free_nxt;
      rs_full  <= (free_nxt == '0);
    end
  end

endmodule
